// File: rtl/ps2_hack_keyboard.sv
// PS/2 Set-2 keyboard receiver and Hack scan-code translator for the memory-mapped keyboard register.
// Optional frame watchdog enabled by defining PS2_WATCHDOG_EN.
module ps2_hack_keyboard #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] hack_scancode,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  logic [2:0] clk_sync;
  logic [2:0] data_sync;
  logic       fall;
  logic       data_bit;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       parity_bit;
  logic       timeout;

  // Synchronisers idle high so that reset release never fakes a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
      fall      <= clk_sync[2] & ~clk_sync[1];
    end
  end

  assign data_bit = data_sync[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= 4'd0;
      shreg      <= 8'd0;
      parity_bit <= 1'b0;
      rx_byte    <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        if (bit_cnt == 4'd0) begin
          if (!data_bit) bit_cnt <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {data_bit, shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          parity_bit <= data_bit;
          bit_cnt    <= 4'd10;
        end else begin
          bit_cnt <= 4'd0;
          if (data_bit && (^{shreg, parity_bit})) begin
            rx_byte    <= shreg;
            byte_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (timeout) begin
        bit_cnt   <= 4'd0;
        frame_err <= 1'b1;
      end
    end
  end

`ifdef PS2_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Counts cycles since the last edge while a frame is open; an edge always wins over expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (fall) begin
      wd_cnt <= WD_W'(1);
    end else if (bit_cnt == 4'd0 || timeout) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign timeout = (bit_cnt != 4'd0) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  function automatic logic [7:0] translate(input logic [8:0] key);
    case (key)
      9'h01C: translate = 8'd65;  9'h032: translate = 8'd66;  9'h021: translate = 8'd67;
      9'h023: translate = 8'd68;  9'h024: translate = 8'd69;  9'h02B: translate = 8'd70;
      9'h034: translate = 8'd71;  9'h033: translate = 8'd72;  9'h043: translate = 8'd73;
      9'h03B: translate = 8'd74;  9'h042: translate = 8'd75;  9'h04B: translate = 8'd76;
      9'h03A: translate = 8'd77;  9'h031: translate = 8'd78;  9'h044: translate = 8'd79;
      9'h04D: translate = 8'd80;  9'h015: translate = 8'd81;  9'h02D: translate = 8'd82;
      9'h01B: translate = 8'd83;  9'h02C: translate = 8'd84;  9'h03C: translate = 8'd85;
      9'h02A: translate = 8'd86;  9'h01D: translate = 8'd87;  9'h022: translate = 8'd88;
      9'h035: translate = 8'd89;  9'h01A: translate = 8'd90;
      9'h045: translate = 8'd48;  9'h016: translate = 8'd49;  9'h01E: translate = 8'd50;
      9'h026: translate = 8'd51;  9'h025: translate = 8'd52;  9'h02E: translate = 8'd53;
      9'h036: translate = 8'd54;  9'h03D: translate = 8'd55;  9'h03E: translate = 8'd56;
      9'h046: translate = 8'd57;
      9'h029: translate = 8'd32;  9'h05A: translate = 8'd128; 9'h066: translate = 8'd129;
      9'h16B: translate = 8'd130; 9'h175: translate = 8'd131; 9'h174: translate = 8'd132;
      9'h172: translate = 8'd133; 9'h16C: translate = 8'd134; 9'h169: translate = 8'd135;
      9'h17D: translate = 8'd136; 9'h17A: translate = 8'd137; 9'h170: translate = 8'd138;
      9'h171: translate = 8'd139; 9'h076: translate = 8'd140;
      9'h005: translate = 8'd141; 9'h006: translate = 8'd142; 9'h004: translate = 8'd143;
      9'h00C: translate = 8'd144; 9'h003: translate = 8'd145; 9'h00B: translate = 8'd146;
      9'h083: translate = 8'd147; 9'h00A: translate = 8'd148; 9'h001: translate = 8'd149;
      9'h009: translate = 8'd150; 9'h078: translate = 8'd151; 9'h007: translate = 8'd152;
      default: translate = 8'd0;
    endcase
  endfunction

  state_t     state, state_next;
  logic       do_make, do_brk, is_ext;
  logic [8:0] key, held_raw;
  logic [7:0] code;

  assign key  = {is_ext, rx_byte};
  assign code = translate(key);

  always_comb begin
    state_next = state;
    do_make    = 1'b0;
    do_brk     = 1'b0;
    is_ext     = (state == EXT) || (state == EXT_BRK);
    if (byte_valid) begin
      case (state)
        IDLE: begin
          if (rx_byte == 8'hF0)      state_next = BRK;
          else if (rx_byte == 8'hE0) state_next = EXT;
          else                       do_make    = 1'b1;
        end
        EXT: begin
          if (rx_byte == 8'hF0) begin
            state_next = EXT_BRK;
          end else begin
            do_make    = 1'b1;
            state_next = IDLE;
          end
        end
        default: begin
          do_brk     = 1'b1;
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      hack_scancode <= 8'd0;
      held_raw      <= 9'd0;
    end else begin
      state <= state_next;
      if (do_make && code != 8'd0) begin
        hack_scancode <= code;
        held_raw      <= key;
      end else if (do_brk && key == held_raw) begin
        hack_scancode <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_hack_keyboard.sv
// Bench for ps2_hack_keyboard: bit-banged PS/2 frames, byte scoreboard and inline key-code checks.
// Watchdog scenario runs only when PS2_WATCHDOG_EN is defined.
module tb_ps2_hack_keyboard;
  localparam int unsigned TMO = 100;

  logic clk = 1'b0, reset_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] hack_scancode, rx_byte;
  logic byte_valid, frame_err;

  int checks = 0, errors = 0, err_seen = 0, both_high = 0, cyc = 0, last_fall = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  ps2_hack_keyboard #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .hack_scancode(hack_scancode), .rx_byte(rx_byte),
    .byte_valid(byte_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (byte_valid) obs_q.push_back(rx_byte);
      if (frame_err) err_seen = err_seen + 1;
      if (byte_valid && frame_err) both_high = both_high + 1;
    end
  end

  logic [8:0] tk [11] = '{9'h01A, 9'h045, 9'h046, 9'h029, 9'h066, 9'h076,
                          9'h005, 9'h083, 9'h007, 9'h171, 9'h17A};
  logic [7:0] tc [11] = '{8'd90, 8'd48, 8'd57, 8'd32, 8'd129, 8'd140,
                          8'd141, 8'd147, 8'd152, 8'd139, 8'd137};

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 ps2_data = bits[i];
      repeat (8) @(posedge clk);
      #1 ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (8) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b, input bit bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    if (!bad_par) exp_q.push_back(b);
    send_bits(frame_of(b, bad_par), 11);
    repeat (20) @(posedge clk);
  endtask

  task automatic press(input logic [8:0] k);
    if (k[8]) send_frame(8'hE0, 1'b0);
    send_frame(k[7:0], 1'b0);
  endtask

  task automatic release_key(input logic [8:0] k);
    if (k[8]) send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(k[7:0], 1'b0);
  endtask

  task automatic pop_pair(output logic [7:0] got, output logic [7:0] want, output bit have);
    have = (obs_q.size() > 0) && (exp_q.size() > 0);
    got  = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({hack_scancode, rx_byte, byte_valid, frame_err} !== 18'd0) begin
      errors++;
      $display("FAIL reset_state: got %h %h %b %b expected all zero",
               hack_scancode, rx_byte, byte_valid, frame_err);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_latency;
    logic bv [1:5];
    logic [7:0] hk [1:5];
    logic [7:0] g, w;
    bit h;
    exp_q.push_back(8'h1C);
    send_bits(frame_of(8'h1C, 1'b0), 10);
    @(posedge clk); #1 ps2_data = 1'b1;
    repeat (8) @(posedge clk);
    #1 ps2_clk = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      bv[k] = byte_valid;
      hk[k] = hack_scancode;
    end
    repeat (3) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    checks++;
    if ({bv[3], bv[4], bv[5]} !== 3'b010) begin
      errors++; $display("FAIL lat_byte_valid: got %b%b%b expected 010", bv[3], bv[4], bv[5]);
    end
    checks++;
    if (hk[4] !== 8'd0 || hk[5] !== 8'd65) begin
      errors++; $display("FAIL lat_hack: got c4=%0d c5=%0d expected 0 65", hk[4], hk[5]);
    end
    release_key(9'h01C);
    checks++;
    if (hack_scancode !== 8'd0) begin
      errors++; $display("FAIL release_A: got %0d expected 0", hack_scancode);
    end
    while (exp_q.size() != 0) begin
      pop_pair(g, w, h); checks++;
      if (!h || g !== w) begin errors++; $display("FAIL latency_bytes: got %h expected %h", g, w); end
    end
  endtask

  task automatic test_extended;
    logic [7:0] g, w;
    bit h;
    press(9'h175);
    checks++;
    if (hack_scancode !== 8'd131) begin errors++; $display("FAIL ext_up: got %0d expected 131", hack_scancode); end
    release_key(9'h175);
    checks++;
    if (hack_scancode !== 8'd0) begin errors++; $display("FAIL ext_up_brk: got %0d expected 0", hack_scancode); end
    press(9'h01C);
    press(9'h075);
    checks++;
    if (hack_scancode !== 8'd65) begin errors++; $display("FAIL keypad8: got %0d expected 65", hack_scancode); end
    press(9'h112);
    release_key(9'h112);
    checks++;
    if (hack_scancode !== 8'd65) begin errors++; $display("FAIL fake_shift: got %0d expected 65", hack_scancode); end
    release_key(9'h01C);
    while (exp_q.size() != 0) begin
      pop_pair(g, w, h); checks++;
      if (!h || g !== w) begin errors++; $display("FAIL ext_bytes: got %h expected %h", g, w); end
    end
  endtask

  task automatic test_last_make_wins;
    logic [7:0] g, w;
    bit h;
    press(9'h01C);
    press(9'h032);
    checks++;
    if (hack_scancode !== 8'd66) begin errors++; $display("FAIL last_make: got %0d expected 66", hack_scancode); end
    release_key(9'h01C);
    checks++;
    if (hack_scancode !== 8'd66) begin errors++; $display("FAIL stale_break: got %0d expected 66", hack_scancode); end
    press(9'h032);
    release_key(9'h032);
    checks++;
    if (hack_scancode !== 8'd0) begin errors++; $display("FAIL held_break: got %0d expected 0", hack_scancode); end
    while (exp_q.size() != 0) begin
      pop_pair(g, w, h); checks++;
      if (!h || g !== w) begin errors++; $display("FAIL lmw_bytes: got %h expected %h", g, w); end
    end
  endtask

  task automatic test_translate;
    logic [7:0] g, w;
    bit h;
    for (int i = 0; i < 11; i++) begin
      press(tk[i]);
      checks++;
      if (hack_scancode !== tc[i]) begin
        errors++; $display("FAIL xlate_%h: got %0d expected %0d", tk[i], hack_scancode, tc[i]);
      end
      release_key(tk[i]);
      checks++;
      if (hack_scancode !== 8'd0) begin
        errors++; $display("FAIL xlate_brk_%h: got %0d expected 0", tk[i], hack_scancode);
      end
    end
    while (exp_q.size() != 0) begin
      pop_pair(g, w, h); checks++;
      if (!h || g !== w) begin errors++; $display("FAIL xlate_bytes: got %h expected %h", g, w); end
    end
  endtask

  task automatic test_parity_err;
    int e0;
    logic [7:0] g, w;
    bit h;
    press(9'h01C);
    e0 = err_seen;
    send_frame(8'h29, 1'b1);
    checks++;
    if (err_seen - e0 !== 1) begin errors++; $display("FAIL parity_err: got %0d pulses expected 1", err_seen - e0); end
    checks++;
    if (hack_scancode !== 8'd65) begin errors++; $display("FAIL parity_hold: got %0d expected 65", hack_scancode); end
    release_key(9'h01C);
    while (exp_q.size() != 0) begin
      pop_pair(g, w, h); checks++;
      if (!h || g !== w) begin errors++; $display("FAIL parity_bytes: got %h expected %h", g, w); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL parity_extra: got %0d stray bytes expected 0", obs_q.size()); end
  endtask

  task automatic test_start_bit;
    int e0;
    logic [7:0] g, w;
    bit h;
    e0 = err_seen;
    send_bits(11'h7FF, 1);
    repeat (20) @(posedge clk);
    press(9'h016);
    checks++;
    if (hack_scancode !== 8'd49 || err_seen != e0) begin
      errors++; $display("FAIL bad_start: got %0d errs=%0d expected 49 errs=0", hack_scancode, err_seen - e0);
    end
    release_key(9'h016);
    while (exp_q.size() != 0) begin
      pop_pair(g, w, h); checks++;
      if (!h || g !== w) begin errors++; $display("FAIL start_bytes: got %h expected %h", g, w); end
    end
  endtask

`ifdef PS2_WATCHDOG_EN
  task automatic test_watchdog;
    int e0, t0, dt;
    logic [7:0] g, w;
    bit h;
    e0 = err_seen;
    send_bits(frame_of(8'h16, 1'b0), 4);
    t0 = last_fall;
    dt = -1;
    for (int k = 0; k < 1000 && dt < 0; k++) begin
      @(negedge clk);
      if (err_seen != e0) dt = cyc - t0;
    end
    checks++;
    if (dt < int'(TMO) || dt > int'(TMO) + 6) begin
      errors++; $display("FAIL watchdog_time: got %0d cycles expected about %0d", dt, TMO);
    end
    checks++;
    if (err_seen - e0 !== 1) begin errors++; $display("FAIL watchdog_pulses: got %0d expected 1", err_seen - e0); end
    press(9'h016);
    checks++;
    if (hack_scancode !== 8'd49) begin errors++; $display("FAIL after_timeout: got %0d expected 49", hack_scancode); end
    release_key(9'h016);
    while (exp_q.size() != 0) begin
      pop_pair(g, w, h); checks++;
      if (!h || g !== w) begin errors++; $display("FAIL wd_bytes: got %h expected %h", g, w); end
    end
  endtask
`endif

  task automatic test_reset_mid_frame;
    logic [7:0] g, w;
    bit h;
    press(9'h01C);
    checks++;
    if (hack_scancode !== 8'd65) begin errors++; $display("FAIL pre_reset_hold: got %0d expected 65", hack_scancode); end
    while (exp_q.size() != 0) begin
      pop_pair(g, w, h); checks++;
      if (!h || g !== w) begin errors++; $display("FAIL pre_reset_bytes: got %h expected %h", g, w); end
    end
    send_bits(frame_of(8'h5A, 1'b0), 6);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({hack_scancode, rx_byte, byte_valid, frame_err} !== 18'd0) begin
      errors++;
      $display("FAIL mid_reset: got %h %h %b %b expected all zero", hack_scancode, rx_byte, byte_valid, frame_err);
    end
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    press(9'h05A);
    checks++;
    if (hack_scancode !== 8'd128) begin errors++; $display("FAIL enter_after_reset: got %0d expected 128", hack_scancode); end
    release_key(9'h05A);
    while (exp_q.size() != 0) begin
      pop_pair(g, w, h); checks++;
      if (!h || g !== w) begin errors++; $display("FAIL post_reset_bytes: got %h expected %h", g, w); end
    end
  endtask

  task automatic test_exclusive;
    checks++;
    if (both_high != 0) begin errors++; $display("FAIL valid_err_overlap: got %0d cycles expected 0", both_high); end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL stray_bytes: got %0d expected 0", obs_q.size()); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_extended;
    test_last_make_wins;
    test_translate;
    test_parity_err;
    test_start_bit;
`ifdef PS2_WATCHDOG_EN
    test_watchdog;
`endif
    test_reset_mid_frame;
    test_exclusive;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ps2_hack_keyboard.md
# ps2_hack_keyboard

PS/2 keyboard receiver and scan-code translator that produces the 8-bit `hack_scancode` consumed by the Hack memory-mapped keyboard register (address 0x6000). It deserialises device-to-host PS/2 frames, decodes Set-2 make/break/extended sequences, and holds the Hack key code while the key is down, returning 0 on release. It sits between the board PS/2 pins and the Memory block, in the slot reserved for the keyboard in the top level.

## Interface
- `TIMEOUT_CYCLES`, 50000: clk cycles without a PS/2 clock edge before an in-progress frame is aborted. 1 ms at 50 MHz.
- `clk` in 1: system clock. Same clock as the CPU.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock from the pin. Asynchronous.
- `ps2_data` in 1: raw PS/2 data from the pin. Asynchronous.
- `hack_scancode` out 8: Hack key code of the currently held key, or 0 when no key is held.
- `rx_byte` out 8: last correctly received raw byte.
- `byte_valid` out 1: one-cycle pulse when `rx_byte` updates.
- `frame_err` out 1: one-cycle pulse on a parity error, stop-bit error or timeout abort.

## Operation
- `ps2_clk` and `ps2_data` pass through 2-flop synchronisers. A falling edge is detected on the synchronised clock, and data is sampled on that edge.
- Frame format: start 0, 8 data bits LSB first, odd parity, stop 1. A bit counter runs 0..10.
- Start bit = 1 is discarded silently and the counter stays at 0.
- Parity or stop-bit failure: the byte is dropped, `frame_err` pulses, and the counter resets.
- Decoder FSM states are IDLE, BRK, EXT and EXT_BRK.
  - IDLE: 0xF0 goes to BRK. 0xE0 goes to EXT. Any other byte is a make and stays in IDLE.
  - EXT: 0xF0 goes to EXT_BRK. Any other byte is an extended make and goes to IDLE.
  - BRK and EXT_BRK: the next byte is a break (normal or extended) and goes to IDLE.
- Translation is combinational on {ext, byte}.
  - Letters 0x1C,0x32,0x21,0x23,0x24,0x2B,0x34,0x33,0x43,0x3B,0x42,0x4B,0x3A,0x31,0x44,0x4D,0x15,0x2D,0x1B,0x2C,0x3C,0x2A,0x1D,0x22,0x35,0x1A map to 'A'..'Z' (65..90).
  - Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to '0'..'9'.
  - Space 0x29 maps to 32.
  - Enter 0x5A maps to 128. Backspace 0x66 maps to 129.
  - Extended keys: left 0x6B→130, up 0x75→131, right 0x74→132, down 0x72→133, home 0x6C→134, end 0x69→135, pgup 0x7D→136, pgdn 0x7A→137, insert 0x70→138, delete 0x71→139.
  - Esc 0x76 maps to 140.
  - F1..F12 map to 141..152: 0x05,0x06,0x04,0x0C,0x03,0x0B,0x83,0x0A,0x01,0x09,0x78,0x07.
  - Everything else is unmapped.
- Mapped make: `hack_scancode` ← code and `held_raw` ← {ext, byte}. Last make wins.
- Unmapped make: no change to `hack_scancode`.
- Break matching `held_raw`: `hack_scancode` ← 0.
- Break not matching `held_raw`: no change.
- Typematic repeat makes rewrite the same value.
- Sequence E0 12 / E0 F0 12 (fake shift) is unmapped and therefore ignored.

## Timing
- Reset values: all outputs are 0, FSM is IDLE, bit counter is 0, `held_raw` is 0.
- Assertion of `reset_n` mid-frame or mid-sequence discards all partial state immediately.
- Pipeline from the stop bit:
  - Stop-bit falling edge on the pin: cycle 0.
  - Synchronised edge detected: cycle 3.
  - `rx_byte` and `byte_valid` updated: cycle 4.
  - `hack_scancode` updated: cycle 5.
- `frame_err` pulses on cycle 4 for parity or stop errors.
- `byte_valid` and `frame_err` are never high in the same cycle.
- An edge arriving in the same cycle as a timeout expiry takes precedence, and no abort occurs.
- Bytes arrive at most every ~100 µs, so no output buffering is required and none is provided.

## Configuration
- `PS2_WATCHDOG_EN` defined:
  - A counter restarts on every falling edge while the bit counter is non-zero.
  - Reaching `TIMEOUT_CYCLES` resets the bit counter and pulses `frame_err`.
  - The decoder FSM is untouched.
- `PS2_WATCHDOG_EN` undefined:
  - No counter and no timeout; the `TIMEOUT_CYCLES` parameter is unused.
  - A lost edge desynchronises framing until reset or until a later bad start bit discards the frame.

## Test plan
- Frame 0x1C with correct odd parity: `rx_byte` = 0x1C, `byte_valid` 1 cycle, `hack_scancode` = 65 five cycles after the stop edge. Then F0 1C returns `hack_scancode` to 0.
- E0 75 (up): `hack_scancode` = 131. Then E0 F0 75 gives 0. A plain 75 (keypad 8) is unmapped, so no change.
- Make 1C then make 32: `hack_scancode` = 66. Then F0 1C gives still 66. Then F0 32 gives 0.
- 0x29 with a wrong parity bit: `frame_err` pulses, `byte_valid` stays 0, `hack_scancode` is unchanged.
- With `PS2_WATCHDOG_EN` and TIMEOUT_CYCLES=100, 4 bits then silence: `frame_err` pulses at cycle 100 after the last edge. A following good 0x16 frame decodes to 49.
- `reset_n` low during bit 5 of a frame, while holding 'A': all outputs go to 0 immediately. The next full frame 0x5A decodes to 128.
